// File: rtl/btn_event_conditioner_pkg.sv
// Shared state encoding, button indices and sizing helper for the button event conditioner.
// No logic here; latency and backpressure are defined by the modules that import it.
package btn_event_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    PRESSED  = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } btn_state_t;

  localparam int BTN_U = 0;
  localparam int BTN_C = 1;
  localparam int BTN_D = 2;

  function automatic int max_ms(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, debounce/repeat FSM with a saturating counter, registered outputs.
// Latency raw->pulse 2+DEB_MS ticks; no backpressure, a press held off by lockout waits in PRESS_DB.
module btn_channel
  import btn_event_conditioner_pkg::*;
#(
  parameter int DEB_MS        = 20,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_MS     = 100,
  parameter int CNT_W         = 10
) (
  input  logic clk_khz_1,
  input  logic reset_task,
  input  logic btn_raw,
  input  logic repeat_en,
  input  logic lockout_active,
  output logic press_fire,
  output logic btn_pulse,
  output logic btn_level,
  output logic btn_rpt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEB_MS);
  localparam logic [CNT_W-1:0] DLY_N   = CNT_W'(REPEAT_DLY_MS - 1);
  localparam logic [CNT_W-1:0] RPT_N   = CNT_W'(REPEAT_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_a, sync_b;
  btn_state_t       state, state_nxt, ret_state, ret_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pulse_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_khz_1 or posedge reset_task) begin
    if (reset_task) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      state     <= IDLE;
      ret_state <= IDLE;
      cnt       <= '0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
      btn_rpt   <= 1'b0;
    end else begin
      sync_a    <= btn_raw;
      sync_b    <= sync_a;
      state     <= state_nxt;
      ret_state <= ret_nxt;
      cnt       <= cnt_nxt;
      btn_pulse <= pulse_nxt;
      btn_level <= (state_nxt inside {PRESSED, REPEAT, REL_DB});
      btn_rpt   <= (state_nxt == REPEAT);
    end
  end

  always_comb begin
    state_nxt  = state;
    ret_nxt    = ret_state;
    cnt_nxt    = cnt;
    pulse_nxt  = 1'b0;
    press_fire = 1'b0;
    case (state)
      IDLE: begin
        if (sync_b) begin
          state_nxt = PRESS_DB;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (!sync_b) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_N) begin
          // Debounced but locked out: hold here and fire on the first clear cycle.
          if (!lockout_active) begin
            state_nxt  = PRESSED;
            cnt_nxt    = '0;
            pulse_nxt  = 1'b1;
            press_fire = 1'b1;
          end
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      PRESSED: begin
        if (!sync_b) begin
          state_nxt = REL_DB;
          ret_nxt   = PRESSED;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == DLY_N && repeat_en) begin
          state_nxt = REPEAT;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      REPEAT: begin
        if (!sync_b) begin
          state_nxt = REL_DB;
          ret_nxt   = REPEAT;
          cnt_nxt   = CNT_ONE;
        end else if (!repeat_en) begin
          // Parked at saturation so the repeat delay can never match again.
          state_nxt = PRESSED;
          cnt_nxt   = CNT_MAX;
        end else if (cnt == RPT_N) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      REL_DB: begin
        if (sync_b) begin
          state_nxt = ret_state;
          cnt_nxt   = '0;
        end else if (cnt == DEB_N) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_event_conditioner.sv
// Button event conditioner: N_BTN debounced channels sharing one press lockout counter.
// Latency raw->pulse 2+DEB_MS ticks (longer under lockout); no backpressure, pulses are fire-and-forget.
module btn_event_conditioner
  import btn_event_conditioner_pkg::*;
#(
  parameter int N_BTN         = 3,
  parameter int DEB_MS        = 20,
  parameter int LOCKOUT_MS    = 200,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_MS     = 100
) (
  input  logic             clk_khz_1,
  input  logic             reset_task,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rpt
);

  localparam int CNT_W  = $clog2(max_ms(DEB_MS, LOCKOUT_MS, REPEAT_DLY_MS, REPEAT_MS)) + 1;
  localparam int LOCK_W = $clog2(LOCKOUT_MS) + 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_MS - 1);

  logic [LOCK_W-1:0] lock_cnt;
  logic [N_BTN-1:0]  press_fire;
  logic              lockout_active;

  assign lockout_active = (lock_cnt != '0);

  // Simultaneous qualifying presses all fire; the lockout is loaded once for the group.
  always_ff @(posedge clk_khz_1 or posedge reset_task) begin
    if (reset_task) begin
      lock_cnt <= '0;
    end else if (|press_fire) begin
      lock_cnt <= LOCK_LOAD;
    end else if (lockout_active) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEB_MS       (DEB_MS),
      .REPEAT_DLY_MS(REPEAT_DLY_MS),
      .REPEAT_MS    (REPEAT_MS),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_khz_1     (clk_khz_1),
      .reset_task    (reset_task),
      .btn_raw       (btn_raw[i]),
      .repeat_en     (repeat_en[i]),
      .lockout_active(lockout_active),
      .press_fire    (press_fire[i]),
      .btn_pulse     (btn_pulse[i]),
      .btn_level     (btn_level[i]),
      .btn_rpt       (btn_rpt[i])
    );
  end

endmodule

// File: tb/tb_btn_event_conditioner.sv
// Bench for btn_event_conditioner: vector table, timed corner sequences, random run vs a timestamp model.
// Outputs are sampled 1 time unit after each rising edge; inputs change only away from edges.
module tb_btn_event_conditioner;

  localparam int N    = 3;
  localparam int DEB  = 4;
  localparam int LOCK = 10;
  localparam int DLY  = 12;
  localparam int RPT  = 3;

  logic         clk_khz_1  = 1'b0;
  logic         reset_task = 1'b1;
  logic [N-1:0] btn_raw    = '0;
  logic [N-1:0] repeat_en  = '0;
  logic [N-1:0] btn_pulse, btn_level, btn_rpt;

  int checks = 0;
  int errors = 0;

  btn_event_conditioner #(
    .N_BTN(N), .DEB_MS(DEB), .LOCKOUT_MS(LOCK), .REPEAT_DLY_MS(DLY), .REPEAT_MS(RPT)
  ) dut (
    .clk_khz_1 (clk_khz_1),
    .reset_task(reset_task),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level),
    .btn_rpt   (btn_rpt)
  );

  always #5 clk_khz_1 = ~clk_khz_1;

  // Reference model: run lengths of synchronised samples and timestamps of the last event.
  bit           model_on = 1'b0;
  int           t;
  int           lock_t;
  logic [N-1:0] m_pipe0, m_pipe1;
  int           ones_run[N], zeros_run[N], anchor[N];
  bit           acc[N], rptg[N], dead[N];
  logic [N-1:0] m_pulse, m_level, m_rpt;

  function automatic void model_reset();
    t = 0;
    lock_t = -100000;
    m_pipe0 = '0;
    m_pipe1 = '0;
    m_pulse = '0;
    m_level = '0;
    m_rpt = '0;
    for (int i = 0; i < N; i++) begin
      ones_run[i] = 0; zeros_run[i] = 0; anchor[i] = 0;
      acc[i] = 0; rptg[i] = 0; dead[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic [N-1:0] raw, input logic [N-1:0] ren);
    logic [N-1:0] s;
    bit lock_clear, any_press;
    s = m_pipe1;
    m_pipe1 = m_pipe0;
    m_pipe0 = raw;
    lock_clear = (t - lock_t) >= LOCK;
    any_press = 0;
    m_pulse = '0;
    for (int i = 0; i < N; i++) begin
      if (!acc[i]) begin
        ones_run[i] = s[i] ? ones_run[i] + 1 : 0;
        if (ones_run[i] >= DEB + 1 && lock_clear) begin
          acc[i] = 1; rptg[i] = 0; dead[i] = 0; zeros_run[i] = 0;
          anchor[i] = t; m_pulse[i] = 1'b1; any_press = 1;
        end
      end else if (!s[i]) begin
        zeros_run[i]++;
        if (zeros_run[i] >= DEB + 1) begin
          acc[i] = 0; rptg[i] = 0; ones_run[i] = 0; zeros_run[i] = 0;
        end
      end else if (zeros_run[i] > 0) begin
        zeros_run[i] = 0; anchor[i] = t; dead[i] = 0;
      end else if (rptg[i]) begin
        if (!ren[i]) begin
          rptg[i] = 0; dead[i] = 1;
        end else if (t - anchor[i] == RPT) begin
          m_pulse[i] = 1'b1; anchor[i] = t;
        end
      end else if (!dead[i] && ren[i] && (t - anchor[i] == DLY)) begin
        rptg[i] = 1; m_pulse[i] = 1'b1; anchor[i] = t;
      end
    end
    if (any_press) lock_t = t;
    for (int i = 0; i < N; i++) begin
      m_level[i] = acc[i];
      m_rpt[i]   = rptg[i] && (zeros_run[i] == 0);
    end
    t++;
  endfunction

  task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [N-1:0] p, input logic [N-1:0] l,
                           input logic [N-1:0] r);
    check_vec({name, " pulse"}, btn_pulse, p);
    check_vec({name, " level"}, btn_level, l);
    check_vec({name, " rpt"}, btn_rpt, r);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_khz_1);
    if (model_on) model_edge(btn_raw, repeat_en);
    #1;
  endtask

  // Reset asserted between edges; outputs must clear without any clock edge.
  task automatic do_reset(input string name);
    #2 reset_task = 1'b1;
    #1 check_out(name, '0, '0, '0);
    @(negedge clk_khz_1);
    reset_task = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] pulse;
    logic [N-1:0] level;
  } vec_t;

  vec_t         vt[$];
  vec_t         v;
  logic [20:0]  bounce_pat;
  logic [31:0]  rel_pat;
  int           npulse;
  int           run_left[N];

  initial begin
    // D bounces (3 high, 1 low, 3 high, low) and must never pulse; U then gets a clean press.
    bounce_pat = 21'h77;
    for (int k = 0; k < 21; k++) begin
      v.raw   = {bounce_pat[k], 1'b0, (k >= 12)};
      v.pulse = (k == 18) ? 3'b001 : 3'b000;
      v.level = (k >= 18) ? 3'b001 : 3'b000;
      vt.push_back(v);
    end

    do_reset("reset");
    for (int k = 0; k < vt.size(); k++) begin
      btn_raw = vt[k].raw;
      tick();
      check_out($sformatf("vec%0d", k), vt[k].pulse, vt[k].level, 3'b000);
    end

    // Lockout: C debounced at 9 while U's lockout runs, so C fires at 16.
    btn_raw = '0;
    do_reset("reset_lock");
    for (int k = 0; k <= 16; k++) begin
      btn_raw = (k >= 3) ? 3'b011 : 3'b001;
      tick();
      if (k == 6)  check_out("lock_u", 3'b001, 3'b001, 3'b000);
      if (k == 15) check_out("lock_c_wait", 3'b000, 3'b001, 3'b000);
      if (k == 16) check_out("lock_c", 3'b010, 3'b011, 3'b000);
    end
    btn_raw = '0;
    repeat (20) tick();
    check_out("lock_released", 3'b000, 3'b000, 3'b000);
    btn_raw = 3'b101;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) check_out("simul_pre", 3'b000, 3'b000, 3'b000);
      if (k == 6) check_out("simul", 3'b101, 3'b101, 3'b000);
    end

    // Auto-repeat on U, then repeat_en dropped.
    btn_raw = '0;
    do_reset("reset_rpt");
    repeat_en = 3'b001;
    btn_raw = 3'b001;
    npulse = 0;
    for (int k = 0; k <= 45; k++) begin
      if (k == 25) repeat_en = 3'b000;
      tick();
      if (k == 6)  check_out("rpt_first", 3'b001, 3'b001, 3'b000);
      if (k == 17) check_out("rpt_before", 3'b000, 3'b001, 3'b000);
      if (k == 18) check_out("rpt_18", 3'b001, 3'b001, 3'b001);
      if (k == 21) check_out("rpt_21", 3'b001, 3'b001, 3'b001);
      if (k == 22) check_out("rpt_22", 3'b000, 3'b001, 3'b001);
      if (k == 24) check_out("rpt_24", 3'b001, 3'b001, 3'b001);
      if (k == 25) check_out("rpt_off", 3'b000, 3'b001, 3'b000);
      if (k > 25 && btn_pulse[0]) npulse++;
    end
    check_int("rpt_after_disable", npulse, 0);

    // Release with 2-cycle glitches; level drops once DEB+1 clean zero samples are seen.
    btn_raw = '0;
    do_reset("reset_rel");
    rel_pat = 32'h333FF;
    npulse = 0;
    for (int k = 0; k <= 30; k++) begin
      btn_raw = {2'b00, rel_pat[k]};
      tick();
      if (k == 6)  check_out("rel_press", 3'b001, 3'b001, 3'b000);
      if (k == 23) check_out("rel_held", 3'b000, 3'b001, 3'b000);
      if (k == 24) check_out("rel_done", 3'b000, 3'b000, 3'b000);
      if (k > 6 && btn_pulse[0]) npulse++;
    end
    check_int("rel_spurious", npulse, 0);

    // Async reset in REPEAT; held button must re-debounce from scratch.
    btn_raw = '0;
    do_reset("reset_mid0");
    repeat_en = 3'b001;
    btn_raw = 3'b001;
    for (int k = 0; k <= 19; k++) tick();
    check_out("mid_in_rpt", 3'b000, 3'b001, 3'b001);
    do_reset("reset_mid");
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (k == 5) check_out("repress_pre", 3'b000, 3'b000, 3'b000);
      if (k == 6) check_out("repress", 3'b001, 3'b001, 3'b000);
    end

    // Random bouncy traffic on all channels against the model, with one reset mid-run.
    btn_raw = '0;
    repeat_en = 3'b111;
    do_reset("reset_rand");
    model_on = 1'b1;
    for (int i = 0; i < N; i++) run_left[i] = $urandom_range(0, 20);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (run_left[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          run_left[i] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : $urandom_range(5, 60);
        end else begin
          run_left[i]--;
        end
      end
      if ($urandom_range(0, 149) == 0) repeat_en = N'($urandom);
      if (c == 2000) do_reset("reset_rand_mid");
      tick();
      check_out($sformatf("rand%0d", c), m_pulse, m_level, m_rpt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
